pci_stream_gearbox: RTL and testbench
=====================================

# pci_stream_gearbox

Parametrised width converter between the byte-wide pixel stream at the host/PCIe boundary and the wide word interface of `procTop` (`i_data_pci` / `o_data_pci`).

- **Ingress:** packs `PIXELS_PER_BEAT` pixels per word.
- **Egress:** unpacks wide words back into single pixels.
- **Framing:** both directions track frame boundaries of `FRAME_PIXELS` pixels and flag frame completion.

It replaces the one-pixel-per-256-bit-word zero padding on the PCIe path with fully packed beats and keep masks.

## Interface

Parameters:
- `PIXEL_W`, 8: bits per pixel.
- `PIXELS_PER_BEAT`, 32: lanes per wide word (P); word width `PIXEL_W*P`.
- `FRAME_PIXELS`, 262144: pixels per frame; must be ≥ 1.
- `CNT_W`, `$clog2(FRAME_PIXELS+1)`: pixel counter width.

Ports:
- `clk`  in  1  single clock, all logic rising-edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  narrow ingress pixel valid.
- `s_data`  in  `PIXEL_W`  ingress pixel.
- `s_ready`  out  1  ingress ready.
- `m_valid`  out  1  packed word valid (to `i_valid_pci`).
- `m_data`  out  `PIXEL_W*P`  packed word; lane k = bits `[k*PIXEL_W +: PIXEL_W]`.
- `m_keep`  out  P  lane valid mask, contiguous from lane 0.
- `m_last`  out  1  word carries last pixel of frame.
- `m_ready`  in  1  downstream ready.
- `e_valid`  in  1  wide egress word valid (from `o_valid_pci`).
- `e_data`  in  `PIXEL_W*P`  wide egress word.
- `e_keep`  in  P  egress lane mask; only contiguous-from-lane-0 masks are legal.
- `e_ready`  out  1  egress word ready (to `i_ready_pci`).
- `o_valid`  out  1  narrow egress pixel valid.
- `o_data`  out  `PIXEL_W`  egress pixel.
- `o_ready`  in  1  narrow egress sink ready.
- `in_frame_done`  out  1  one-cycle pulse: last ingress word of a frame accepted by sink.
- `out_frame_done`  out  1  one-cycle pulse: last egress pixel of a frame accepted by sink.

## Operation

**Ingress packer**
- Assembly register doubles as output register.
- State: lane index `in_idx` (0..P-1) and frame counter `in_cnt` (0..`FRAME_PIXELS`-1).
- `s_ready = !m_valid | m_ready`.
- On accept (`s_valid & s_ready`):
  - Pixel is written to lane `in_idx` and `m_keep[in_idx]` is set.
  - If `m_valid & m_ready` in the same cycle, the old word retires first: the new pixel lands in lane 0 of a fresh word with keep = `1<<0`.
- Word closes (`m_valid`←1 next edge) when `in_idx==P-1` or `in_cnt==FRAME_PIXELS-1`.
  - Frame-end close also sets `m_last`.
  - `in_idx` then resets to 0.
  - `in_cnt` wraps to 0 at frame end.
- Lanes not written in a short final word are 0.
- `m_data`/`m_keep`/`m_last` are held stable while `m_valid & !m_ready`.
- `in_frame_done` pulses the cycle after `m_valid & m_ready & m_last`.

**Egress unpacker**
- Holding register: word, `n_lanes` (popcount of `e_keep`), out index `out_idx`, and `busy`.
- `e_ready = !busy | (o_valid & o_ready & out_idx==n_lanes-1)`, which allows back-to-back words with no bubble.
- On word accept:
  - `e_keep==0`: word is dropped and `busy` stays 0.
  - Otherwise `busy`←1 and `out_idx`←0.
- `o_valid = busy`; `o_data` = lane `out_idx`.
- On `o_valid & o_ready`: `out_idx` increments; `busy` clears after lane `n_lanes-1` unless a new word is accepted in the same cycle.
- `out_cnt` counts emitted pixels.
  - At `FRAME_PIXELS-1` accepted, it wraps to 0 and `out_frame_done` pulses next cycle.
  - Egress framing is pixel-count based; no `e_last` is needed.

## Timing

- Reset (async assert, synchronous-safe deassert), all outputs 0: `s_ready`=0 during reset and 1 the first cycle after, `m_valid`, `m_keep`, `m_last`, `m_data`, `e_ready` (1 after reset), `o_valid`, both done pulses. Counters and indices are 0.
- Ingress latency: the word is valid 1 cycle after its closing pixel is accepted. Sustained rate is 1 pixel/cycle with an always-ready sink.
- Egress latency: first pixel on `o_valid` 1 cycle after word accept. Sustained rate is 1 pixel/cycle.
- Reset mid-frame discards partial words and both frame counters; the next pixel is lane 0, pixel 0.
- `m_ready` low stalls ingress after at most one full word; no pixel is lost or duplicated.

## Test plan

- **Packing:** P=32, `FRAME_PIXELS`=64, feed 0..63 with `m_ready`=1 → 2 words, lane k = k and k+32; keep=all ones; `m_last` only on word 2; `in_frame_done` one pulse.
- **Partial final word:** `FRAME_PIXELS`=40, P=32 → word 2 keep=`0xFF`, lanes 8..31 = 0, `m_last`=1; counter wraps; next frame starts at lane 0.
- **Ingress backpressure:** `m_ready` toggled with a random 50% pattern, 1000 pixels → output sequence identical to input; `s_ready` low only while a full word is stalled.
- **Egress:** words keep=all ones, then keep=`0x3`, then keep=0, with `o_ready` random → pixels emitted in lane order, keep=0 word produces nothing, `e_ready` reasserts the same cycle the last lane is taken.
- **Loopback image:** loop `m_*` → `e_*`, 262144-pixel frame (P=32, `PIXEL_W`=8) → bytes out identical to bytes in; `out_frame_done` pulses once at pixel 262144.
- **Reset mid-operation:** assert `rstn`=0 with 5 pixels assembled and `busy`=1 → all outputs 0 immediately; after release the first pixel lands in lane 0 and the frame counts from 0.

Source files
------------

// File: rtl/pci_stream_gearbox.sv
// Width converter between a one-pixel stream and packed multi-lane words, in both directions,
// with pixel-count based frame tracking and one-cycle frame-done pulses.
module pci_stream_gearbox #(
    parameter int PIXEL_W         = 8,
    parameter int PIXELS_PER_BEAT = 32,
    parameter int FRAME_PIXELS    = 262144,
    parameter int CNT_W           = $clog2(FRAME_PIXELS + 1)
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               s_valid,
    input  logic [PIXEL_W-1:0]                 s_data,
    output logic                               s_ready,
    output logic                               m_valid,
    output logic [PIXEL_W*PIXELS_PER_BEAT-1:0] m_data,
    output logic [PIXELS_PER_BEAT-1:0]         m_keep,
    output logic                               m_last,
    input  logic                               m_ready,
    input  logic                               e_valid,
    input  logic [PIXEL_W*PIXELS_PER_BEAT-1:0] e_data,
    input  logic [PIXELS_PER_BEAT-1:0]         e_keep,
    output logic                               e_ready,
    output logic                               o_valid,
    output logic [PIXEL_W-1:0]                 o_data,
    input  logic                               o_ready,
    output logic                               in_frame_done,
    output logic                               out_frame_done
);
    localparam int P     = PIXELS_PER_BEAT;
    localparam int W     = PIXEL_W * P;
    localparam int IDX_W = (P > 1) ? $clog2(P) : 1;
    localparam int NL_W  = $clog2(P + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);

    logic             r_active;
    logic             r_m_valid;
    logic [W-1:0]     r_m_data;
    logic [P-1:0]     r_m_keep;
    logic             r_m_last;
    logic [IDX_W-1:0] r_in_idx;
    logic [CNT_W-1:0] r_in_cnt;
    logic             r_in_done;

    logic             w_retire;
    logic             w_s_accept;
    logic             w_frame_end;
    logic             w_close;
    logic [W-1:0]     w_fill_data;
    logic [P-1:0]     w_fill_keep;

    assign s_ready       = r_active & (~r_m_valid | m_ready);
    assign m_valid       = r_m_valid;
    assign m_data        = r_m_data;
    assign m_keep        = r_m_keep;
    assign m_last        = r_m_last;
    assign in_frame_done = r_in_done;

    assign w_retire    = r_m_valid & m_ready;
    assign w_s_accept  = s_valid & s_ready;
    assign w_frame_end = (r_in_cnt == LAST_CNT);
    assign w_close     = (r_in_idx == LAST_IDX) | w_frame_end;

    // A retiring word is replaced by a zeroed one, so an accepted pixel starts a fresh word.
    always_comb begin
        w_fill_data = w_retire ? '0 : r_m_data;
        w_fill_keep = w_retire ? '0 : r_m_keep;
        w_fill_data[r_in_idx*PIXEL_W +: PIXEL_W] = s_data;
        w_fill_keep[r_in_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_active  <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_in_idx  <= '0;
            r_in_cnt  <= '0;
            r_in_done <= 1'b0;
        end else begin
            r_active  <= 1'b1;
            r_in_done <= w_retire & r_m_last;
            if (w_s_accept) begin
                r_m_data  <= w_fill_data;
                r_m_keep  <= w_fill_keep;
                r_m_valid <= w_close;
                r_m_last  <= w_frame_end;
                r_in_idx  <= w_close ? '0 : r_in_idx + 1'b1;
                r_in_cnt  <= w_frame_end ? '0 : r_in_cnt + 1'b1;
            end else if (w_retire) begin
                r_m_valid <= 1'b0;
                r_m_data  <= '0;
                r_m_keep  <= '0;
                r_m_last  <= 1'b0;
            end
        end
    end

    logic [W-1:0]     r_e_data;
    logic [NL_W-1:0]  r_n_lanes;
    logic [NL_W-1:0]  r_out_idx;
    logic             r_busy;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_out_done;

    logic [NL_W-1:0]  w_e_pop;
    logic             w_o_take;
    logic             w_last_lane;
    logic             w_e_accept;

    always_comb begin
        w_e_pop = '0;
        for (int unsigned k = 0; k < P; k++) begin
            w_e_pop = w_e_pop + NL_W'(e_keep[k]);
        end
    end

    assign w_o_take    = r_busy & o_ready;
    assign w_last_lane = (r_out_idx == r_n_lanes - NL_W'(1));
    // Taking the final lane frees the holding register in the same cycle, so words run back to back.
    assign e_ready     = r_active & (~r_busy | (w_o_take & w_last_lane));
    assign w_e_accept  = e_valid & e_ready;

    assign o_valid        = r_busy;
    assign o_data         = r_e_data[r_out_idx*PIXEL_W +: PIXEL_W];
    assign out_frame_done = r_out_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_e_data   <= '0;
            r_n_lanes  <= '0;
            r_out_idx  <= '0;
            r_busy     <= 1'b0;
            r_out_cnt  <= '0;
            r_out_done <= 1'b0;
        end else begin
            r_out_done <= w_o_take & (r_out_cnt == LAST_CNT);
            if (w_o_take) begin
                r_out_cnt <= (r_out_cnt == LAST_CNT) ? '0 : r_out_cnt + 1'b1;
                if (w_last_lane) begin
                    r_busy <= 1'b0;
                end else begin
                    r_out_idx <= r_out_idx + 1'b1;
                end
            end
            if (w_e_accept && (w_e_pop != '0)) begin
                r_e_data  <= e_data;
                r_n_lanes <= w_e_pop;
                r_out_idx <= '0;
                r_busy    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pci_stream_gearbox.sv
// Directed bench for pci_stream_gearbox with 4 lanes of 8 bits and a 10-pixel frame,
// so every packed word and emitted pixel can be written out by hand.
module tb_pci_stream_gearbox;
    localparam int PW = 8;
    localparam int P  = 4;
    localparam int FP = 10;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_valid, s_ready;
    logic [PW-1:0] s_data;
    logic          m_valid, m_last, m_ready;
    logic [PW*P-1:0] m_data;
    logic [P-1:0]  m_keep;
    logic          e_valid, e_ready;
    logic [PW*P-1:0] e_data;
    logic [P-1:0]  e_keep;
    logic          o_valid, o_ready;
    logic [PW-1:0] o_data;
    logic          in_frame_done, out_frame_done;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_w [3] = '{32'h13121110, 32'h17161514, 32'h00001918};
    logic [3:0]  exp_k [3] = '{4'hF, 4'hF, 4'h3};

    always #5 clk = ~clk;

    pci_stream_gearbox #(
        .PIXEL_W(PW),
        .PIXELS_PER_BEAT(P),
        .FRAME_PIXELS(FP)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_keep(m_keep),
        .m_last(m_last),
        .m_ready(m_ready),
        .e_valid(e_valid),
        .e_data(e_data),
        .e_keep(e_keep),
        .e_ready(e_ready),
        .o_valid(o_valid),
        .o_data(o_data),
        .o_ready(o_ready),
        .in_frame_done(in_frame_done),
        .out_frame_done(out_frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        e_valid = 1'b0; e_data = '0; e_keep = '0; o_ready = 1'b0;

        #12;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_e_ready", e_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_keep", m_keep, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_in_done", in_frame_done, 0);
        chk("rst_out_done", out_frame_done, 0);
        rstn = 1'b1;
        tick();
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_e_ready", e_ready, 1);

        // Full frame, always-ready sink: words close after pixels 3, 7 and 9.
        m_ready = 1'b1;
        for (int i = 0; i < FP; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h10 + i);
            tick();
            if (i == 3 || i == 7 || i == 9) begin
                chk("pack_valid", m_valid, 1);
                chk("pack_data", m_data, exp_w[i/4]);
                chk("pack_keep", m_keep, exp_k[i/4]);
                chk("pack_last", m_last, (i == 9));
            end else begin
                chk("pack_idle", m_valid, 0);
                chk("pack_no_done", in_frame_done, 0);
            end
        end
        s_valid = 1'b0;
        tick();
        chk("in_done_pulse", in_frame_done, 1);
        chk("retired_valid", m_valid, 0);
        tick();
        chk("in_done_clear", in_frame_done, 0);

        // Stalled sink: a full word holds, s_ready drops, pending pixel waits.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'hA0 + i);
            tick();
        end
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, 32'hA3A2A1A0);
        chk("stall_keep", m_keep, 4'hF);
        chk("stall_last", m_last, 0);
        s_data = 8'hA4;
        #1;
        chk("stall_s_ready", s_ready, 0);
        tick();
        tick();
        chk("stall_hold_data", m_data, 32'hA3A2A1A0);
        chk("stall_hold_valid", m_valid, 1);
        m_ready = 1'b1;
        #1;
        chk("unstall_s_ready", s_ready, 1);
        tick();
        chk("fresh_valid", m_valid, 0);
        chk("fresh_keep", m_keep, 4'h1);
        chk("fresh_data", m_data, 32'h000000A4);
        s_valid = 1'b0;

        // Egress: full word, then keep=0x3, then keep=0.
        o_ready = 1'b1;
        e_valid = 1'b1;
        e_data  = 32'h44332211;
        e_keep  = 4'hF;
        #1;
        chk("eg_ready_idle", e_ready, 1);
        tick();
        chk("eg_valid", o_valid, 1);
        chk("eg_px0", o_data, 8'h11);
        chk("eg_busy_ready", e_ready, 0);
        e_data  = 32'hDEADBBAA;
        e_keep  = 4'h3;
        o_ready = 1'b0;
        tick();
        chk("eg_stall_px0", o_data, 8'h11);
        o_ready = 1'b1;
        tick();
        chk("eg_px1", o_data, 8'h22);
        tick();
        chk("eg_px2", o_data, 8'h33);
        tick();
        chk("eg_px3", o_data, 8'h44);
        chk("eg_ready_last_lane", e_ready, 1);
        tick();
        chk("eg_w2_px0", o_data, 8'hAA);
        chk("eg_w2_ready", e_ready, 0);
        e_data = 32'hFFFFFFFF;
        e_keep = 4'h0;
        tick();
        chk("eg_w2_px1", o_data, 8'hBB);
        chk("eg_w2_ready_last", e_ready, 1);
        tick();
        chk("eg_keep0_dropped", o_valid, 0);
        e_valid = 1'b0;
        tick();
        chk("eg_idle", o_valid, 0);
        chk("eg_no_done", out_frame_done, 0);

        // Pixels 7..10 of the egress frame.
        e_valid = 1'b1;
        e_data  = 32'h88776655;
        e_keep  = 4'hF;
        tick();
        e_valid = 1'b0;
        chk("eg_f_px6", o_data, 8'h55);
        tick();
        chk("eg_f_px7", o_data, 8'h66);
        tick();
        chk("eg_f_px8", o_data, 8'h77);
        chk("eg_f_no_done", out_frame_done, 0);
        tick();
        chk("eg_f_px9", o_data, 8'h88);
        tick();
        chk("out_done_pulse", out_frame_done, 1);
        chk("eg_f_idle", o_valid, 0);
        tick();
        chk("out_done_clear", out_frame_done, 0);

        // Reset with a partial ingress word and a busy egress register.
        e_valid = 1'b1;
        e_data  = 32'hCAFEF00D;
        e_keep  = 4'hF;
        o_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hB0;
        tick();
        e_valid = 1'b0;
        s_data  = 8'hB1;
        tick();
        s_valid = 1'b0;
        chk("pre_rst_keep", m_keep, 4'h7);
        chk("pre_rst_busy", o_valid, 1);
        chk("pre_rst_o_data", o_data, 8'h0D);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_keep", m_keep, 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_o_valid", o_valid, 0);
        chk("mid_rst_o_data", o_data, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_e_ready", e_ready, 0);
        tick();
        rstn = 1'b1;
        tick();
        chk("rerst_s_ready", s_ready, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h50 + i);
            tick();
            if (i == 0) begin
                chk("rerst_lane0_keep", m_keep, 4'h1);
                chk("rerst_lane0_data", m_data, 32'h00000050);
            end
            if (i < 3) chk("rerst_no_close", m_valid, 0);
        end
        chk("rerst_word_valid", m_valid, 1);
        chk("rerst_word_data", m_data, 32'h53525150);
        chk("rerst_word_last", m_last, 0);
        chk("rerst_o_valid", o_valid, 0);
        s_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
